// File: rtl/pdm_decimator_pkg.sv
// Shared audio types for the record/playback path.
// Sample format, capture FSM states and offset/signed conversion.
package audio_pkg;

  localparam int SAMPLE_WIDTH = 16;

  typedef logic [SAMPLE_WIDTH-1:0] sample_t;

  typedef enum logic {
    IDLE,
    RUN
  } pdm_state_t;

  function automatic logic signed [SAMPLE_WIDTH-1:0] offset_to_signed(
    input sample_t s
  );
    return {~s[SAMPLE_WIDTH-1], s[SAMPLE_WIDTH-2:0]};
  endfunction

  function automatic sample_t signed_to_offset(
    input logic signed [SAMPLE_WIDTH-1:0] s
  );
    return {~s[SAMPLE_WIDTH-1], s[SAMPLE_WIDTH-2:0]};
  endfunction

endpackage

// File: rtl/pdm_decimator_if.sv
// Controller-side enable/done handshake carrying one sample per window.
// master = controller, slave = producer of samples.
interface pdm_decimator_if #(
  parameter int SAMPLE_WIDTH = audio_pkg::SAMPLE_WIDTH
);

  logic                    enable_i;
  logic                    done_o;
  logic [SAMPLE_WIDTH-1:0] data_o;

  modport master (
    output enable_i,
    input  done_o,
    input  data_o
  );

  modport slave (
    input  enable_i,
    output done_o,
    output data_o
  );

endinterface

// File: rtl/pdm_decimator_clock_gen.sv
// PDM microphone clock divider.
// rise_stb is high in the first cycle the PDM clock reads high.
module pdm_clock_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic enable,
  input  logic clear,
  output logic pdm_clk,
  output logic rise_stb
);

  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0] div_cnt;
  logic          wrap;

  assign wrap = (div_cnt == DW'(CLK_DIV - 1));

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      div_cnt  <= '0;
      pdm_clk  <= 1'b0;
      rise_stb <= 1'b0;
    end else if (clear) begin
      div_cnt  <= '0;
      pdm_clk  <= 1'b0;
      rise_stb <= 1'b0;
    end else if (enable) begin
      rise_stb <= wrap & ~pdm_clk;
      if (wrap) begin
        div_cnt <= '0;
        pdm_clk <= ~pdm_clk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end else begin
      rise_stb <= 1'b0;
    end
  end

endmodule

// File: rtl/pdm_decimator.sv
// PDM capture: boxcar ones-count decimation to offset-binary samples.
// Define PDM_DC_BLOCK_EN to insert a first-order DC blocker (+1 cycle).
module pdm_decimator #(
  parameter int CLK_DIV      = 25,
  parameter int DECIMATION   = 128,
  parameter int SAMPLE_WIDTH = audio_pkg::SAMPLE_WIDTH
) (
  input  logic           clock_i,
  input  logic           reset_i,
  pdm_decimator_if.slave bus,
  output logic           pdm_clk_o,
  input  logic           pdm_data_i,
  output logic           pdm_lrsel_o
);

  import audio_pkg::*;

  localparam int LW = $clog2(DECIMATION);
  localparam int SH = SAMPLE_WIDTH - LW;

  pdm_state_t state, state_nx;

  logic                    run;
  logic                    clear_div;
  logic                    rise_stb;
  logic [1:0]              sync_q;
  logic                    pdm_bit;
  logic [LW-1:0]           bit_cnt;
  logic [LW:0]             ones_cnt;
  logic [LW:0]             ones_sum;
  logic                    last_bit;
  logic [LW-1:0]           sat;
  logic [SAMPLE_WIDTH-1:0] raw;
  logic                    done_q;
  logic [SAMPLE_WIDTH-1:0] data_q;

  assign pdm_lrsel_o = 1'b0;
  assign bus.done_o  = done_q;
  assign bus.data_o  = data_q;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.enable_i)  state_nx = RUN;
      RUN:  if (!bus.enable_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign run       = (state == RUN) && bus.enable_i;
  assign clear_div = ~run;

  pdm_clock_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .enable   (run),
    .clear    (clear_div),
    .pdm_clk  (pdm_clk_o),
    .rise_stb (rise_stb)
  );

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], pdm_data_i};
  end

  assign pdm_bit  = sync_q[1];
  assign ones_sum = ones_cnt + (LW + 1)'(pdm_bit);
  // A window ending as enable drops is still published.
  assign last_bit = rise_stb && (bit_cnt == '1);
  assign sat      = ones_sum[LW] ? '1 : ones_sum[LW-1:0];
  assign raw      = {sat, {SH{1'b0}}};

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      bit_cnt  <= '0;
      ones_cnt <= '0;
    end else if (rise_stb && !last_bit && run) begin
      bit_cnt  <= bit_cnt + 1'b1;
      ones_cnt <= ones_sum;
    end else if (last_bit || !run) begin
      bit_cnt  <= '0;
      ones_cnt <= '0;
    end
  end

`ifdef PDM_DC_BLOCK_EN
  localparam int AW = SAMPLE_WIDTH + 2;
  localparam logic signed [AW-1:0] Y_MAX =
    {3'b000, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] Y_MIN =
    {3'b111, {(SAMPLE_WIDTH-1){1'b0}}};

  function automatic logic signed [AW-1:0] sx(
    input logic signed [SAMPLE_WIDTH-1:0] v
  );
    return {{2{v[SAMPLE_WIDTH-1]}}, v};
  endfunction

  sample_t                        raw_q;
  logic                           raw_vld;
  logic signed [SAMPLE_WIDTH-1:0] x_cur;
  logic signed [SAMPLE_WIDTH-1:0] x_prev;
  logic signed [SAMPLE_WIDTH-1:0] y_prev;
  logic signed [SAMPLE_WIDTH-1:0] y_sat;
  logic signed [AW-1:0]           acc;

  assign x_cur = offset_to_signed(raw_q);
  assign acc   = sx(x_cur) - sx(x_prev) + sx(y_prev)
               - sx(y_prev >>> 8);

  always_comb begin
    y_sat = acc[SAMPLE_WIDTH-1:0];
    if (acc > Y_MAX)      y_sat = Y_MAX[SAMPLE_WIDTH-1:0];
    else if (acc < Y_MIN) y_sat = Y_MIN[SAMPLE_WIDTH-1:0];
  end

  // Filter history survives enable drops; only reset clears it.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      raw_q   <= '0;
      raw_vld <= 1'b0;
      x_prev  <= '0;
      y_prev  <= '0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      raw_vld <= last_bit;
      done_q  <= raw_vld;
      if (last_bit) raw_q <= raw;
      if (raw_vld) begin
        x_prev <= x_cur;
        y_prev <= y_sat;
        data_q <= signed_to_offset(y_sat);
      end
    end
  end
`else
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      done_q <= 1'b0;
      data_q <= '0;
    end else begin
      done_q <= last_bit;
      if (last_bit) data_q <= raw;
    end
  end
`endif

endmodule

// File: tb/tb_pdm_decimator.sv
// Scoreboard bench for pdm_decimator: directed PDM patterns,
// enable drop, async reset; monitor pops expectations on done.
module tb_pdm_decimator;

  localparam int CLK_DIV = 25;
  localparam int DEC     = 128;
  localparam int PERIOD  = 2 * CLK_DIV * DEC;
`ifdef PDM_DC_BLOCK_EN
  localparam int LAT = CLK_DIV * (2 * DEC - 1) + 2;
`else
  localparam int LAT = CLK_DIV * (2 * DEC - 1) + 1;
`endif

  logic clock_i = 1'b0;
  logic reset_i = 1'b0;
  logic pdm_clk_o;
  logic pdm_lrsel_o;
  logic pdm_data_i;
  logic level   = 1'b0;
  logic tog_bit = 1'b0;
  logic tog_en  = 1'b0;

  int cyc      = 0;
  int checks   = 0;
  int errors   = 0;
  int run0     = 0;
  int last_exp = 0;
  int pd, pc;
  int exp_data[$];
  int exp_cyc[$];
`ifdef PDM_DC_BLOCK_EN
  int xp = 0;
  int yp = 0;
`endif

  pdm_decimator_if bus ();

  pdm_decimator #(
    .CLK_DIV      (CLK_DIV),
    .DECIMATION   (DEC),
    .SAMPLE_WIDTH (16)
  ) dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .bus         (bus),
    .pdm_clk_o   (pdm_clk_o),
    .pdm_data_i  (pdm_data_i),
    .pdm_lrsel_o (pdm_lrsel_o)
  );

  assign pdm_data_i = tog_en ? tog_bit : level;

  always #5 clock_i = ~clock_i;

  always @(posedge clock_i) cyc <= cyc + 1;

  always @(posedge pdm_clk_o) if (tog_en) tog_bit <= ~tog_bit;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic int model(input int raw);
`ifdef PDM_DC_BLOCK_EN
    int x;
    int a;
    x = raw - 32768;
    a = x - xp + yp - (yp >>> 8);
    if (a > 32767)  a = 32767;
    if (a < -32768) a = -32768;
    xp = x;
    yp = a;
    return a + 32768;
`else
    return raw;
`endif
  endfunction

  // Monitor: every done pulse must match the head of the queue.
  always @(negedge clock_i) begin
    if (reset_i && bus.done_o) begin
      if (exp_data.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got data %h at cyc %0d, none expected",
                 bus.data_o, cyc);
      end else begin
        pd = exp_data.pop_front();
        pc = exp_cyc.pop_front();
        check("done_cycle", cyc, pc);
        check("done_data", {16'h0, bus.data_o}, pd);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock_i);
  endtask

  task automatic start_run(input int raw, input int n);
    run0 = cyc + 1;
    bus.enable_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      last_exp = model(raw);
      exp_data.push_back(last_exp);
      exp_cyc.push_back(run0 + LAT + i * PERIOD);
    end
  endtask

  task automatic finish_run(input int n);
    wait_until(run0 + LAT + (n - 1) * PERIOD + 5);
    check("all_dones_seen", exp_data.size(), 0);
    bus.enable_i = 1'b0;
    @(negedge clock_i);
    check("pdm_clk_idle", pdm_clk_o, 0);
    repeat (10) @(negedge clock_i);
  endtask

  initial begin
    int highs;
    bus.enable_i = 1'b0;
    repeat (3) @(negedge clock_i);
    check("rst_done", bus.done_o, 0);
    check("rst_data", bus.data_o, 0);
    check("rst_pdm_clk", pdm_clk_o, 0);
    check("rst_lrsel", pdm_lrsel_o, 0);
    reset_i = 1'b1;
    repeat (2) @(negedge clock_i);

    // Constant ones: saturates to 127<<9.
    level = 1'b1;
    start_run(16'hFE00, 2);
    wait_until(run0 + CLK_DIV - 1);
    check("pdm_clk_pre_rise", pdm_clk_o, 0);
    wait_until(run0 + CLK_DIV);
    check("pdm_clk_rise", pdm_clk_o, 1);
    wait_until(run0 + 2 * CLK_DIV);
    check("pdm_clk_fall", pdm_clk_o, 0);
    finish_run(2);

    // Constant zeros.
    level = 1'b0;
    start_run(16'h0000, 2);
    finish_run(2);

    // Alternating bits: 64 ones per window.
    tog_en = 1'b1;
    start_run(16'h8000, 2);
    finish_run(2);
    tog_en = 1'b0;

    // Enable dropped mid-window: nothing published.
    level = 1'b1;
    start_run(0, 0);
    wait_until(run0 + 3000);
    bus.enable_i = 1'b0;
    @(negedge clock_i);
    check("drop_pdm_clk", pdm_clk_o, 0);
    highs = 0;
    repeat (300) begin
      @(negedge clock_i);
      if (pdm_clk_o) highs++;
    end
    check("drop_pdm_clk_stays_low", highs, 0);
    check("drop_data_held", {16'h0, bus.data_o}, last_exp);

    // Re-enable: fresh window, then async reset mid-window.
    start_run(16'hFE00, 1);
    wait_until(run0 + LAT + 3000);
    check("reenable_done_seen", exp_data.size(), 0);
    check("lrsel_run", pdm_lrsel_o, 0);
    reset_i = 1'b0;
    #1;
    check("arst_data", bus.data_o, 0);
    check("arst_done", bus.done_o, 0);
    check("arst_pdm_clk", pdm_clk_o, 0);
    check("arst_lrsel", pdm_lrsel_o, 0);
`ifdef PDM_DC_BLOCK_EN
    xp = 0;
    yp = 0;
`endif
    bus.enable_i = 1'b0;
    repeat (3) @(negedge clock_i);
    reset_i = 1'b1;
    repeat (50) @(negedge clock_i);
    check("post_rst_pdm_clk", pdm_clk_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cyc %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/pdm_decimator.md
Name: pdm_decimator

Overview:
- Upstream capture stage of the record path. Drives the PDM microphone clock and samples the 1-bit PDM stream.
- Decimates the stream with a boxcar ones-count over a fixed window and presents one 16-bit unsigned (offset-binary) sample per window.
- Uses the enable/done handshake the controller already uses for the serializer and timer.
- Consumer: the controller and memory write path. Its output format matches what the PWM serializer plays back.

Parameters:
- CLK_DIV, 25, system-clock cycles per PDM clock half-period (100 MHz / 50 = 2 MHz). Legal range ≥ 4.
- DECIMATION, 128, PDM bits per output sample. Must be a power of two, 16..1024.
- SAMPLE_WIDTH, 16, output sample width.

Ports:
- clock_i  input  1  100 MHz system clock
- reset_i  input  1  reset; asynchronous, active-low
- enable_i  input  1  run capture while high
- done_o  output  1  one-cycle pulse; data_o holds a new sample
- data_o  output  SAMPLE_WIDTH  last completed sample, offset-binary
- pdm_clk_o  output  1  microphone clock
- pdm_data_i  input  1  microphone PDM data (asynchronous)
- pdm_lrsel_o  output  1  channel select; constant 0 (left, data valid on rising edge)

Behaviour:
- Reset (reset_i low, asynchronous):
  - state=IDLE; done_o=0; data_o=0; pdm_clk_o=0.
  - Divider, bit counter and ones counter cleared; sync flops cleared. pdm_lrsel_o=0 always.
- pdm_data_i passes through a 2-flop synchronizer before use (fixed 2-cycle latency; tolerated because CLK_DIV ≥ 4).
- States: IDLE, RUN.
- IDLE:
  - pdm_clk_o=0; counters held at 0.
  - enable_i=1 moves to RUN next cycle. Call the first RUN cycle "cycle 0".
- RUN, divider:
  - div_cnt counts 0..CLK_DIV-1. At wrap, pdm_clk_o toggles.
  - So pdm_clk_o rises at cycles CLK_DIV*(2k-1), k≥1.
- RUN, accumulation:
  - On each cycle where pdm_clk_o goes 0→1, the synchronized data bit is sampled.
  - ones_cnt += bit; bit_cnt increments.
- Window complete (the DECIMATION-th sample):
  - Next cycle: data_o = min(ones_cnt, DECIMATION-1) << (SAMPLE_WIDTH - log2(DECIMATION)).
  - done_o=1 for exactly one cycle.
  - ones_cnt and bit_cnt clear without gaps; the next window starts immediately and the PDM clock is not interrupted.
- First-done latency: cycle CLK_DIV*(2*DECIMATION-1)+1. With defaults this is cycle 6376; samples follow every 2*CLK_DIV*DECIMATION = 6400 cycles.
- Saturation: an all-ones window (count = DECIMATION) clamps to DECIMATION-1, so a full-scale window maps to the maximum representable value without overflow.
- enable_i falling in RUN:
  - Return to IDLE next cycle; pdm_clk_o forced 0.
  - The partial window is discarded and no done_o is produced.
  - data_o retains the last completed sample.
- enable_i re-asserted: starts a fresh window at cycle 0.
- Window completing on the same cycle enable_i falls: the sample is still published (done_o pulses), then IDLE.
- data_o is stable between done pulses and is never updated without done_o.

Optional Feature:
- Macro: PDM_DC_BLOCK_EN.
- Defined: first-order DC blocker between the boxcar and data_o.
  - x = offset-binary sample converted to two's complement (MSB flipped).
  - y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> 8), using a 2-bit-wider internal accumulator saturated to SAMPLE_WIDTH.
  - data_o = y with MSB flipped back to offset-binary.
  - Adds exactly 1 cycle to done_o latency. Filter state clears on reset only, not on enable_i drop.
- Not defined: raw boxcar output as above; no extra latency.

Decomposition:
- Package audio_pkg:
  - SAMPLE_WIDTH constant and sample_t typedef (logic [SAMPLE_WIDTH-1:0]), shared with the serializer and memory.
  - pdm_state_t enum {IDLE, RUN}.
  - Helper function offset_to_signed / signed_to_offset.
- Sub-module pdm_clock_gen: owns div_cnt and pdm_clk_o. Emits a 1-cycle rise_stb; in/out are enable and clear.
- Accumulation, saturation, the optional filter and the handshake stay in pdm_decimator.

Test Plan:
- pdm_data_i=1 constant, enable high (defaults) → first done_o at cycle 6376, data_o=16'hFE00 (127<<9); subsequent dones every 6400 cycles.
- pdm_data_i=0 constant → data_o=16'h0000 with each done_o.
- pdm_data_i toggling each PDM rising edge → data_o=16'h8000 (64<<9).
- enable_i dropped at cycle 3000 → no done_o; pdm_clk_o low the next cycle and stays low; data_o unchanged. Re-enable → first done 6376 cycles later.
- reset_i pulsed low mid-window after one completed sample → immediate data_o=0, done_o=0, pdm_clk_o=0 without waiting for a clock edge; pdm_lrsel_o=0 throughout.
- PDM_DC_BLOCK_EN defined, constant all-ones input → done latency 6377; data_o decays toward 16'h8000 over successive samples.
